// File: rtl/regfile_sb.sv
// regfile_sb: register file with x0 hardwired to zero, write-to-read bypass and a per-register pending-write scoreboard.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int ABITS = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ABITS-1:0]      rd,
    input  logic [XLEN-1:0]       wd,
    input  logic                  claim,
    input  logic [ABITS-1:0]      claim_rd,
    input  logic [NRD*ABITS-1:0]  rs,
    output logic [NRD*XLEN-1:0]   r,
    output logic [NRD-1:0]        busy,
    output logic                  any_pending
);
    logic [XLEN-1:0]  mem_q [NREG];
    logic [XLEN-1:0]  mem_d [NREG];
    logic [NREG-1:0]  pending_q, pending_d;
    logic [ABITS-1:0] addr [NRD];
    logic [NRD-1:0]   byp;

    always_comb begin
        mem_d = mem_q;
        if (we && rd != '0) mem_d[rd] = wd;
        pending_d = '0;
        // a same-cycle claim wins over writeback: it belongs to a newer producer
        for (int k = 1; k < NREG; k++)
            pending_d[k] = (claim && claim_rd == ABITS'(k)) | (pending_q[k] & ~(we && rd == ABITS'(k)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) mem_q[k] <= '0;
            pending_q <= '0;
        end else begin
            mem_q     <= mem_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        r    = '0;
        busy = '0;
        byp  = '0;
        for (int p = 0; p < NRD; p++) begin
            addr[p] = rs[p*ABITS +: ABITS];
            byp[p]  = BYPASS != 0 && we && rd == addr[p] && addr[p] != '0;
            r[p*XLEN +: XLEN] = addr[p] == '0 ? '0 : byp[p] ? wd : mem_q[addr[p]];
            busy[p] = addr[p] != '0 && pending_q[addr[p]] && !byp[p];
        end
    end

    assign any_pending = |pending_q;
endmodule
